// File: rtl/float_pkg.sv
// Shared definitions for the float conversion blocks: FSM state encoding
// and the exponent-bias / integer saturation-limit helpers.
package float_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int exp_bias(input int exponent_width);
    return (1 << (exponent_width - 1)) - 1;
  endfunction

  // Largest positive two's-complement value of a w-bit integer.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Magnitude of the most negative w-bit integer (also its bit pattern).
  function automatic longint sat_min_mag(input int w);
    return longint'(1) <<< (w - 1);
  endfunction

endpackage

// File: rtl/is_special_float.sv
// Classifies the exponent/mantissa part of a float as NaN, infinity,
// zero or denormal. The sign is irrelevant here and is not an input.
module is_special_float #(
  parameter int EXPONENT_WIDTH = 8,
  parameter int MANTISSA_WIDTH = 23
) (
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH-1:0] magnitude,
  output logic                                     is_nan,
  output logic                                     is_inf,
  output logic                                     is_zero,
  output logic                                     is_denormal
);

  logic exp_ones;
  logic exp_zero;
  logic man_zero;

  assign exp_ones = &magnitude[EXPONENT_WIDTH+MANTISSA_WIDTH-1:MANTISSA_WIDTH];
  assign exp_zero = ~|magnitude[EXPONENT_WIDTH+MANTISSA_WIDTH-1:MANTISSA_WIDTH];
  assign man_zero = ~|magnitude[MANTISSA_WIDTH-1:0];

  assign is_nan      = exp_ones & ~man_zero;
  assign is_inf      = exp_ones &  man_zero;
  assign is_zero     = exp_zero &  man_zero;
  assign is_denormal = exp_zero & ~man_zero;

endmodule

// File: rtl/float_to_int_converter.sv
// Multi-cycle float to signed integer converter: a bit-serial barrel shift
// (one position per cycle) followed by a single rounding/saturation cycle.
module float_to_int_converter
  import float_pkg::*;
#(
  parameter int EXPONENT_WIDTH   = 8,
  parameter int MANTISSA_WIDTH   = 23,
  parameter int INT_WIDTH        = 32,
  parameter int ROUND_TO_NEAREST = 1
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic [EXPONENT_WIDTH+MANTISSA_WIDTH:0] a,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [INT_WIDTH-1:0]                   out,
  output logic                                   overflow_flag,
  output logic                                   invalid_operation_flag,
  output logic                                   inexact_flag
);

  localparam int FW   = EXPONENT_WIDTH + MANTISSA_WIDTH + 1;
  localparam int WW   = INT_WIDTH + 2;
  localparam int CW   = $clog2(INT_WIDTH + MANTISSA_WIDTH + 2);
  localparam int BIAS = exp_bias(EXPONENT_WIDTH);

  localparam logic [INT_WIDTH-1:0] INT_MAX     = INT_WIDTH'(sat_max(INT_WIDTH));
  localparam logic [INT_WIDTH-1:0] INT_MIN     = INT_WIDTH'(sat_min_mag(INT_WIDTH));
  localparam logic [WW-1:0]        MAG_MAX_POS = WW'(sat_max(INT_WIDTH));
  localparam logic [WW-1:0]        MAG_MAX_NEG = WW'(sat_min_mag(INT_WIDTH));

  state_e                     state;
  logic                       sign_r;
  logic                       dir_left;
  logic [CW-1:0]              count;
  logic [WW-1:0]              work;
  logic                       guard;
  logic                       sticky;

  logic                       sign_in;
  logic [EXPONENT_WIDTH-1:0]  exp_in;
  logic [MANTISSA_WIDTH-1:0]  man_in;
  logic                       is_nan;
  logic                       is_inf;
  logic                       is_zero;
  logic                       is_denormal;

  int                         e_in;
  logic                       left_in;
  logic [CW-1:0]              shift_count_in;

  logic                       go_special;
  logic [INT_WIDTH-1:0]       special_out;
  logic                       special_ovf;
  logic                       special_inv;
  logic                       special_inx;

  logic                       round_up;
  logic [WW-1:0]              mag_rounded;
  logic [WW-1:0]              neg_mag;
  logic [INT_WIDTH-1:0]       round_out;
  logic                       round_ovf;

  assign sign_in  = a[FW-1];
  assign exp_in   = a[FW-2:MANTISSA_WIDTH];
  assign man_in   = a[MANTISSA_WIDTH-1:0];
  assign in_ready = (state == IDLE);

  is_special_float #(
    .EXPONENT_WIDTH (EXPONENT_WIDTH),
    .MANTISSA_WIDTH (MANTISSA_WIDTH)
  ) u_special (
    .magnitude   (a[FW-2:0]),
    .is_nan      (is_nan),
    .is_inf      (is_inf),
    .is_zero     (is_zero),
    .is_denormal (is_denormal)
  );

  // Unbiased exponent and the distance between the binary point and the
  // integer LSB; only meaningful when the operand takes the normal path.
  always_comb begin
    e_in           = int'(exp_in) - BIAS;
    left_in        = (e_in > MANTISSA_WIDTH);
    shift_count_in = left_in ? CW'(e_in - MANTISSA_WIDTH) : CW'(MANTISSA_WIDTH - e_in);
  end

  always_comb begin
    go_special  = 1'b0;
    special_out = '0;
    special_ovf = 1'b0;
    special_inv = 1'b0;
    special_inx = 1'b0;
    if (is_nan) begin
      go_special  = 1'b1;
      special_out = INT_MIN;
      special_inv = 1'b1;
    end else if (is_inf) begin
      go_special  = 1'b1;
      special_out = sign_in ? INT_MIN : INT_MAX;
      special_ovf = 1'b1;
    end else if (is_zero || is_denormal) begin
      go_special  = 1'b1;
      special_inx = is_denormal;
    end else if (e_in < -1) begin
      // Magnitude below one half always truncates to zero, even under RNE.
      go_special  = 1'b1;
      special_inx = 1'b1;
    end else if (e_in >= INT_WIDTH - 1) begin
      go_special = 1'b1;
      if (sign_in) begin
        special_out = INT_MIN;
        special_ovf = !((e_in == INT_WIDTH - 1) && (man_in == '0));
      end else begin
        special_out = INT_MAX;
        special_ovf = 1'b1;
      end
    end
  end

  always_comb begin
    round_up    = (ROUND_TO_NEAREST != 0) && guard && (sticky || work[0]);
    mag_rounded = work + WW'(round_up);
    neg_mag     = WW'(0) - mag_rounded;
    round_out   = '0;
    round_ovf   = 1'b0;
    if (sign_r) begin
      if (mag_rounded > MAG_MAX_NEG) begin
        round_out = INT_MIN;
        round_ovf = 1'b1;
      end else begin
        round_out = neg_mag[INT_WIDTH-1:0];
      end
    end else begin
      if (mag_rounded > MAG_MAX_POS) begin
        round_out = INT_MAX;
        round_ovf = 1'b1;
      end else begin
        round_out = mag_rounded[INT_WIDTH-1:0];
      end
    end
  end

  // Right shifts feed the discarded bit into guard and fold the previous
  // guard into sticky, so rounding sees exactly the bits below the LSB.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state                  <= IDLE;
      sign_r                 <= 1'b0;
      dir_left               <= 1'b0;
      count                  <= '0;
      work                   <= '0;
      guard                  <= 1'b0;
      sticky                 <= 1'b0;
      out                    <= '0;
      out_valid              <= 1'b0;
      overflow_flag          <= 1'b0;
      invalid_operation_flag <= 1'b0;
      inexact_flag           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sign_r   <= sign_in;
            dir_left <= left_in;
            count    <= shift_count_in;
            work     <= WW'({1'b1, man_in});
            guard    <= 1'b0;
            sticky   <= 1'b0;
            if (go_special) begin
              out                    <= special_out;
              overflow_flag          <= special_ovf;
              invalid_operation_flag <= special_inv;
              inexact_flag           <= special_inx;
              out_valid              <= 1'b1;
              state                  <= DONE;
            end else begin
              overflow_flag          <= 1'b0;
              invalid_operation_flag <= 1'b0;
              inexact_flag           <= 1'b0;
              state                  <= (shift_count_in == '0) ? ROUND : SHIFT;
            end
          end
        end
        SHIFT: begin
          if (dir_left) begin
            work <= work << 1;
          end else begin
            work   <= work >> 1;
            guard  <= work[0];
            sticky <= sticky | guard;
          end
          count <= count - CW'(1);
          if (count == CW'(1)) begin
            state <= ROUND;
          end
        end
        ROUND: begin
          out                    <= round_out;
          overflow_flag          <= round_ovf;
          invalid_operation_flag <= 1'b0;
          inexact_flag           <= guard | sticky;
          out_valid              <= 1'b1;
          state                  <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/float_to_int_converter.md
FLOAT_TO_INT_CONVERTER -- requirements
Module: float_to_int_converter

Interface
REQ-001 Parameters SHALL be (name, default, meaning):
- EXPONENT_WIDTH, 8, float exponent bits
- MANTISSA_WIDTH, 23, float stored mantissa bits
- INT_WIDTH, 32, signed two's-complement result width
- ROUND_TO_NEAREST, 1, 1 = round-to-nearest-even, 0 = truncate toward zero
REQ-002 Ports SHALL be (name direction width meaning):
- clk  in  1  single clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  input float present
- in_ready  out  1  block accepts input
- a  in  EXPONENT_WIDTH+MANTISSA_WIDTH+1  float operand {sign, exponent, mantissa}
- out_valid  out  1  result present
- out_ready  in  1  consumer takes result
- out  out  INT_WIDTH  signed integer result
- overflow_flag  out  1  result saturated
- invalid_operation_flag  out  1  operand was NaN
- inexact_flag  out  1  nonzero bits discarded

Function
REQ-003 Transfers SHALL occur only on in_valid&&in_ready (accept) and out_valid&&out_ready (deliver).
REQ-004 FSM states SHALL be IDLE, SHIFT, ROUND, DONE; in_ready SHALL equal (state==IDLE).
REQ-005 On accept, the block SHALL register the sign, e = exponent - (2^(EXPONENT_WIDTH-1)-1), and significand {1, mantissa} into a working register of INT_WIDTH+2 bits plus guard and sticky.
REQ-006 Special path (IDLE->DONE directly) SHALL apply to: NaN; infinity; exponent==0 (zero or denormal); e < -1; e >= INT_WIDTH-1.
REQ-007 Special results SHALL be:
- NaN -> out = -2^(INT_WIDTH-1), invalid_operation_flag=1
- +inf or positive e>=INT_WIDTH-1 -> 2^(INT_WIDTH-1)-1, overflow_flag=1
- -inf or negative e>=INT_WIDTH-1 -> -2^(INT_WIDTH-1); overflow_flag=1 unless the value is exactly -2^(INT_WIDTH-1)
- exponent==0 or e<-1 -> 0, inexact_flag = (operand magnitude nonzero)
REQ-008 Normal path: shift count S = |MANTISSA_WIDTH - e|; right shift if e<MANTISSA_WIDTH, else left shift. S==0 SHALL go IDLE->ROUND directly.
REQ-009 SHIFT SHALL move exactly one bit per cycle and decrement the counter; on right shifts, the bit shifted out SHALL enter guard and the old guard SHALL OR into sticky.
REQ-010 ROUND (one cycle) SHALL do the following:
- if ROUND_TO_NEAREST, increment the magnitude when guard && (sticky || lsb)
- set inexact_flag = guard||sticky
- negate if sign
- if the rounded magnitude exceeds range, saturate per REQ-007 with overflow_flag=1
REQ-011 Latency: accept at cycle t -> out_valid at t+S+2 (normal) or t+1 (special).
REQ-012 While out_valid=1 && out_ready=0, out and all flags SHALL hold stable; the delivery cycle SHALL return the FSM to IDLE, and the flags SHALL clear on the next accept.
REQ-013 in_valid SHALL be ignored outside IDLE; no input is buffered.

Reset
REQ-014 rst SHALL immediately (asynchronously) force state=IDLE, out=0, out_valid=0, all flags=0, and clear the counter and working registers.
REQ-015 Reset mid-SHIFT or in DONE SHALL discard the conversion, with no out_valid pulse afterward; in_ready=1 on the first clock after rst deasserts.

Structure
REQ-016 The shared package float_pkg SHALL hold the FSM state enum and the bias/saturation-limit constant functions.
REQ-017 The block SHALL instantiate the existing is_special_float for NaN/infinity/zero detection; all other logic SHALL be local.

Verification (float32 -> int32 defaults)
REQ-018 a=0x3FC00000 (1.5), RNE -> out=2, inexact=1, out_valid at t+25; with ROUND_TO_NEAREST=0 -> out=1, inexact=1.
REQ-019 a=0xC0200000 (-2.5) -> out=-2 (ties-to-even), inexact=1; a=0x4B000001 (8388609.0, S=0) -> out=8388609, no flags, out_valid at t+2.
REQ-020 Overflow boundaries:
- a=0x4F000000 (2^31) -> 0x7FFFFFFF, overflow=1
- a=0xCF000000 (-2^31) -> 0x80000000, no flags
- a=0xFF800000 (-inf) -> 0x80000000, overflow=1
REQ-021 Invalid and zero-like inputs:
- a=0x7FC00000 -> 0x80000000, invalid=1, out_valid at t+1
- a=0x00000001 -> 0, inexact=1
- a=0x00000000 -> 0, no flags
REQ-022 Hold out_ready=0 for 5 cycles after out_valid -> out, flags and out_valid stable, in_ready=0; then assert rst during SHIFT of a new conversion -> out_valid=0 immediately, in_ready=1 after release, no stale result.
